mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the multicycle RV32I core's fetch/load/store port: accepts one request at a time,
//  inserts programmable wait states, performs byte/half/word access into a local word-addressed RAM and
//  returns sign/zero-extended load data or a store acknowledge. Sits between the core's IorD address mux and memory.
// PARAMETERS
//  DEPTH_WORDS  1024  RAM depth in 32-bit words (power of two); AW = log2(DEPTH_WORDS)
//  WAIT_STATES  1     idle cycles inserted between acceptance and the access; 0..15 legal
//  INIT_FILE    ""    hex image loaded at elaboration ($readmemh); empty = no preload
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  clr        in   1   reset, synchronous, active-high
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept; handshake when req_valid & req_ready
//  req_addr   in   32  byte address
//  req_we     in   1   1 = store, 0 = load/fetch
//  req_func3  in   3   RV32I width code (fetch uses 3'b010)
//  req_wdata  in   32  store data, LSB-aligned (byte in [7:0], half in [15:0])
//  rsp_valid  out  1   one-cycle response strobe
//  rsp_rdata  out  32  extended load data; 0 for stores and errors
//  rsp_err    out  1   misaligned or illegal func3; valid with rsp_valid
// BEHAVIOUR
//  Reset (clr=1 at edge): state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; RAM contents kept.
//  req_ready = (state==IDLE) & !clr, combinational; no request accepted in a reset cycle.
//  FSM: IDLE -> (handshake) latch addr/we/func3/wdata -> WAIT if WAIT_STATES>0 else ACCESS.
//    WAIT: counter counts 0..WAIT_STATES-1, then -> ACCESS. ACCESS: RAM read/write, -> RESP.
//    RESP: rsp_valid=1 for exactly one cycle with rdata/err, -> IDLE. Back-to-back: next accept in the cycle after RESP.
//  Latency: rsp_valid asserts WAIT_STATES+2 cycles after the handshake edge (WAIT_STATES=0 -> 2).
//  Request fields are sampled only at handshake; later changes on req_* are ignored.
//  Word index = addr[AW+1:2]; higher address bits ignored (aliasing wrap-around, no error).
//  Loads: 000 LB sign-ext, 001 LH sign-ext, 010 LW, 100 LBU zero-ext, 101 LHU zero-ext; byte lane = addr[1:0],
//    half lane = addr[1]. 011/110/111 -> rsp_err=1, rdata=0.
//  Stores: 000 SB, 001 SH, 010 SW write only the addressed lanes from wdata LSBs; others -> rsp_err=1.
//  Misalignment: half with addr[0]=1, word with addr[1:0]!=0 -> rsp_err=1, rdata=0, no RAM write.
//  Errored stores never modify RAM; errored loads still take full latency.
//  Store commits on the ACCESS->RESP edge; clr asserted on or before that edge aborts the store (no write).
//  clr mid-operation in any state: pending request dropped silently, no rsp_valid issued.
//  rsp_rdata/rsp_err hold their values outside RESP (deassert only via reset); consumers qualify with rsp_valid.
// STRUCTURE
//  Package rv_mem_pkg: func3 localparams (F3_B/H/W/BU/HU), state enum (IDLE/WAIT/ACCESS/RESP), width constants;
//    shared with the core control and datapath.
//  Sub-module mem_lane_align (combinational): func3+addr[1:0]+wdata -> byte-enable[3:0], shifted wdata,
//    misalign/illegal flag; raw word+addr[1:0]+func3 -> extended rdata. FSM, counter and RAM stay in top.
// TESTING
//  SW 0xDEADBEEF @0x10, then LW @0x10, WAIT_STATES=1 -> two rsp_valid, second rdata=0xDEADBEEF, err=0, latency 3.
//  After above: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
//  SB 0x12345677 @0x11 then LW @0x10 -> 0xDEAD77EF; SH 0xAAAA1234 @0x12 then LW -> 0x123477EF.
//  LW @0x02, SH @0x01, LH func3=011 -> each rsp_err=1, rdata=0; following LW @0x00 shows memory unchanged.
//  SW 0x55 @0x20 with clr pulsed in ACCESS -> no rsp_valid, req_ready=1 next cycle, LW @0x20 returns old value.
//  DEPTH_WORDS=1024: SW 0x1 @0x1000 then LW @0x0 -> 0x00000001 (alias); WAIT_STATES=0 latency=2 checked.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared definitions for the RV32I memory port: func3 width codes, responder states
// and data widths, used by the core control, the datapath and the memory responder.
package rv_mem_pkg;

    localparam int XLEN = 32;
    localparam int WS_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the memory responder: store byte enables and lane-replicated
// write data, access legality, and sign/zero extension of the raw RAM word for loads.
module mem_lane_align
    import rv_mem_pkg::*;
(
    input  logic            is_store,
    input  logic [2:0]      func3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] raw_word,
    output logic [3:0]      byte_en,
    output logic [XLEN-1:0] wdata_sh,
    output logic            err,
    output logic [XLEN-1:0] rdata_ext
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        illegal;
    logic        misalign;

    always_comb begin
        illegal   = 1'b0;
        misalign  = 1'b0;
        byte_en   = 4'b0000;
        wdata_sh  = '0;
        rdata_ext = '0;
        sel_byte  = 8'(raw_word >> {addr_lo, 3'b000});
        sel_half  = 16'(raw_word >> {addr_lo[1], 4'b0000});

        // Write data is replicated across all lanes; byte_en picks the lanes that commit.
        case (func3)
            F3_B: begin
                byte_en   = 4'b0001 << addr_lo;
                wdata_sh  = {4{wdata[7:0]}};
                rdata_ext = {{24{sel_byte[7]}}, sel_byte};
            end
            F3_H: begin
                misalign  = addr_lo[0];
                byte_en   = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_sh  = {2{wdata[15:0]}};
                rdata_ext = {{16{sel_half[15]}}, sel_half};
            end
            F3_W: begin
                misalign  = (addr_lo != 2'b00);
                byte_en   = 4'b1111;
                wdata_sh  = wdata;
                rdata_ext = raw_word;
            end
            F3_BU: begin
                illegal   = is_store;
                rdata_ext = {24'b0, sel_byte};
            end
            F3_HU: begin
                illegal   = is_store;
                misalign  = addr_lo[0];
                rdata_ext = {16'b0, sel_half};
            end
            default: illegal = 1'b1;
        endcase

        err = illegal | misalign;
        if (err || !is_store) begin
            byte_en = 4'b0000;
        end
        if (err || is_store) begin
            rdata_ext = '0;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts a request, inserts WAIT_STATES idle cycles,
// accesses a word-addressed RAM in ACCESS, and formats the registered response in RESP.
module mem_responder
    import rv_mem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    WAIT_STATES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int              AW      = $clog2(DEPTH_WORDS);
    localparam logic [WS_W-1:0] WS_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    mem_state_e      state_q, state_d;
    logic [WS_W-1:0] cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [2:0]      func3_q, func3_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic [31:0]     mem [DEPTH_WORDS];
    logic [31:0]     rd_word_q;
    logic            mem_we;
    logic [3:0]      byte_en;
    logic [31:0]     wdata_sh;
    logic            acc_err;
    logic [31:0]     rdata_ext;
    logic [AW-1:0]   word_idx;
    logic            unused_addr;

    // Address bits above the RAM size alias silently.
    assign unused_addr = ^req_addr[31:AW+2];
    assign word_idx    = addr_q[AW+1:2];
    assign req_ready   = (state_q == IDLE) && !clr;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;

    mem_lane_align u_align (
        .is_store  (we_q),
        .func3     (func3_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .raw_word  (rd_word_q),
        .byte_en   (byte_en),
        .wdata_sh  (wdata_sh),
        .err       (acc_err),
        .rdata_ext (rdata_ext)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        func3_d     = func3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    we_d    = req_we;
                    func3_d = req_func3;
                    addr_d  = req_addr[AW+1:0];
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (cnt_q == WS_LAST) begin
                    cnt_d   = '0;
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACCESS: begin
                mem_we  = !acc_err;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = rdata_ext;
                rsp_err_d   = acc_err;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            func3_q     <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            func3_q     <= func3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // RAM keeps its contents through reset; a reset on the commit edge cancels the store.
    always_ff @(posedge clk) begin
        if (mem_we && !clr) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
                end
            end
        end
        rd_word_q <= mem[word_idx];
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: two instances (WAIT_STATES=1 and 0) share the request
// inputs; a vector table covers widths, lanes, errors and aliasing, plus a reset-abort sequence.
module tb_mem_responder;
    import rv_mem_pkg::*;

    logic        clk = 1'b0;
    logic        clr;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        req_ready1, rsp_valid1, rsp_err1;
    logic [31:0] rsp_rdata1;
    logic        req_ready0, rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .INIT_FILE("")) dut1 (
        .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready1),
        .req_addr(req_addr), .req_we(req_we), .req_func3(req_func3), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
        .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready0),
        .req_addr(req_addr), .req_we(req_we), .req_func3(req_func3), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    // Called #1 after a rising edge with both instances idle; runs a fixed 8-cycle window.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata,
                       output logic [31:0] rd1, output logic e1, output int lat1, output int n1,
                       output logic [31:0] rd0, output logic e0, output int lat0, output int n0);
        rd1 = 'x; e1 = 1'bx; lat1 = -1; n1 = 0;
        rd0 = 'x; e0 = 1'bx; lat0 = -1; n0 = 0;
        req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        // Scramble the request fields after the handshake; the responder must ignore them.
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_func3 = 3'($urandom_range(0, 7));
        req_addr  = $urandom;
        req_wdata = $urandom;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (rsp_valid1) begin
                n1++;
                if (lat1 < 0) begin lat1 = c; rd1 = rsp_rdata1; e1 = rsp_err1; end
            end
            if (rsp_valid0) begin
                n0++;
                if (lat0 < 0) begin lat0 = c; rd0 = rsp_rdata0; e0 = rsp_err0; end
            end
        end
    endtask

    initial begin
        logic [31:0] rd1, rd0;
        logic        e1, e0;
        int          lat1, lat0, n1, n0;
        logic        seen;

        clr = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'b000;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready_during_clr", 32'(req_ready1), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid1 | rsp_valid0), 32'd0);
        check("rst_rsp_rdata", rsp_rdata1 | rsp_rdata0, 32'd0);
        check("rst_rsp_err", 32'(rsp_err1 | rsp_err0), 32'd0);
        clr = 1'b0;
        #1;
        check("ready1_after_rst", 32'(req_ready1), 32'd1);
        check("ready0_after_rst", 32'(req_ready0), 32'd1);
        @(posedge clk); #1;

        add(1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
        add(1'b0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
        add(1'b0, F3_B,  32'h13, 32'h0,        32'hFFFFFFDE, 1'b0);
        add(1'b0, F3_BU, 32'h13, 32'h0,        32'h000000DE, 1'b0);
        add(1'b0, F3_H,  32'h12, 32'h0,        32'hFFFFDEAD, 1'b0);
        add(1'b0, F3_HU, 32'h10, 32'h0,        32'h0000BEEF, 1'b0);
        add(1'b1, F3_B,  32'h11, 32'h12345677, 32'h0,        1'b0);
        add(1'b0, F3_W,  32'h10, 32'h0,        32'hDEAD77EF, 1'b0);
        add(1'b1, F3_H,  32'h12, 32'hAAAA1234, 32'h0,        1'b0);
        add(1'b0, F3_W,  32'h10, 32'h0,        32'h123477EF, 1'b0);
        add(1'b1, F3_W,  32'h00, 32'hCAFEF00D, 32'h0,        1'b0);
        add(1'b0, F3_W,  32'h02, 32'h0,        32'h0,        1'b1);
        add(1'b1, F3_H,  32'h01, 32'h0000FFFF, 32'h0,        1'b1);
        add(1'b0, 3'b011, 32'h00, 32'h0,       32'h0,        1'b1);
        add(1'b1, F3_BU, 32'h00, 32'h0,        32'h0,        1'b1);
        add(1'b0, 3'b111, 32'h00, 32'h0,       32'h0,        1'b1);
        add(1'b0, F3_W,  32'h00, 32'h0,        32'hCAFEF00D, 1'b0);
        add(1'b0, F3_B,  32'h00, 32'h0,        32'h0000000D, 1'b0);
        add(1'b0, F3_B,  32'h01, 32'h0,        32'hFFFFFFF0, 1'b0);
        add(1'b0, F3_H,  32'h00, 32'h0,        32'hFFFFF00D, 1'b0);
        add(1'b0, F3_HU, 32'h02, 32'h0,        32'h0000CAFE, 1'b0);
        add(1'b1, F3_W,  32'h1000, 32'h1,      32'h0,        1'b0);
        add(1'b0, F3_W,  32'h00, 32'h0,        32'h00000001, 1'b0);
        add(1'b0, F3_W,  32'h1010, 32'h0,      32'h123477EF, 1'b0);
        add(1'b1, F3_W,  32'h20, 32'h11111111, 32'h0,        1'b0);
        add(1'b0, F3_W,  32'h20, 32'h0,        32'h11111111, 1'b0);

        foreach (vecs[i]) begin
            check($sformatf("v%0d_ready", i), 32'(req_ready1 & req_ready0), 32'd1);
            txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                rd1, e1, lat1, n1, rd0, e0, lat0, n0);
            check($sformatf("v%0d_count_ws1", i), 32'(n1), 32'd1);
            check($sformatf("v%0d_latency_ws1", i), 32'(lat1), 32'd3);
            check($sformatf("v%0d_rdata_ws1", i), rd1, vecs[i].exp_rdata);
            check($sformatf("v%0d_err_ws1", i), 32'(e1), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_count_ws0", i), 32'(n0), 32'd1);
            check($sformatf("v%0d_latency_ws0", i), 32'(lat0), 32'd2);
            check($sformatf("v%0d_rdata_ws0", i), rd0, vecs[i].exp_rdata);
            check($sformatf("v%0d_err_ws0", i), 32'(e0), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_rdata_hold", i), rsp_rdata1, vecs[i].exp_rdata);
            check($sformatf("v%0d_err_hold", i), 32'(rsp_err1), 32'(vecs[i].exp_err));
        end

        // Reset pulse on the edge where WAIT_STATES=1 leaves ACCESS and WAIT_STATES=0 leaves RESP.
        req_valid = 1'b1; req_we = 1'b1; req_func3 = F3_W; req_addr = 32'h20; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        seen = rsp_valid1 | rsp_valid0;
        @(posedge clk); #1;
        seen = seen | rsp_valid1 | rsp_valid0;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        #1;
        check("clr_ready1_next", 32'(req_ready1), 32'd1);
        check("clr_ready0_next", 32'(req_ready0), 32'd1);
        check("clr_rdata_cleared", rsp_rdata1 | rsp_rdata0, 32'd0);
        for (int c = 0; c < 6; c++) begin
            seen = seen | rsp_valid1 | rsp_valid0;
            @(posedge clk); #1;
        end
        check("clr_no_rsp_valid", 32'(seen), 32'd0);

        txn(1'b0, F3_W, 32'h20, 32'h0, rd1, e1, lat1, n1, rd0, e0, lat0, n0);
        check("clr_reload_count_ws1", 32'(n1), 32'd1);
        check("clr_reload_latency_ws1", 32'(lat1), 32'd3);
        check("clr_in_access_no_write", rd1, 32'h11111111);
        check("clr_in_access_err", 32'(e1), 32'd0);
        check("clr_reload_count_ws0", 32'(n0), 32'd1);
        check("clr_in_resp_write_kept", rd0, 32'h00000055);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
